// File: rtl/btn_edit_conditioner_if.sv
// Button-bus interface for btn_edit_conditioner.
//   btn_raw          raw asynchronous key inputs (polarity set by the conditioner's ACTIVE_LOW)
//   btn_edit_export  per-button one-cycle press/repeat pulse, active-high
//   btn_level        per-button debounced pressed level, active-high
// Modports:
//   master  conditioner side: reads the raw keys, drives the cleaned outputs
//   slave   board/consumer side: drives the raw keys, reads the cleaned outputs
interface btn_edit_conditioner_if #(
  parameter int unsigned NUM_BTN = 2
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_edit_export;
  logic [NUM_BTN-1:0] btn_level;

  modport master (
    input  btn_raw,
    output btn_edit_export,
    output btn_level
  );

  modport slave (
    output btn_raw,
    input  btn_edit_export,
    input  btn_level
  );
endinterface

// File: rtl/btn_edit_conditioner.sv
// Alarm-clock edit-button conditioner: per button a 2-FF synchroniser, polarity
// normalisation, debounce FSM and (optionally) auto-repeat. Produces clean one-cycle
// press pulses and a debounced pressed level, both registered.
//
// Ports:
//   clk_clk      system clock
//   reset_reset  asynchronous, active-high reset
//   bus          btn_edit_conditioner_if.master (btn_raw in, btn_edit_export/btn_level out)
//
// Build option:
//   BTN_EDIT_AUTO_REPEAT_EN  when defined, a held key emits repeat pulses after
//                            REPEAT_DELAY_CYCLES and then every REPEAT_RATE_CYCLES.
//                            When undefined, one pulse per accepted press and the
//                            REPEAT_* parameters have no effect.
module btn_edit_conditioner #(
  parameter int unsigned NUM_BTN             = 2,
  parameter int unsigned ACTIVE_LOW          = 1,
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  btn_edit_conditioner_if.master bus
);

`ifdef BTN_EDIT_AUTO_REPEAT_EN
  localparam int unsigned MaxDebDelay = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                        DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int unsigned CntMax      = (MaxDebDelay > REPEAT_RATE_CYCLES) ?
                                        MaxDebDelay : REPEAT_RATE_CYCLES;
`else
  // Repeat timing is irrelevant here; it is masked out so only the debounce sizes the counter.
  localparam int unsigned CntMax = DEBOUNCE_CYCLES + (REPEAT_DELAY_CYCLES & 32'd0) +
                                   (REPEAT_RATE_CYCLES & 32'd0);
`endif
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_EDIT_AUTO_REPEAT_EN
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE_CYCLES - 1);
`endif

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StDebPress  = 3'd1;
  localparam logic [2:0] StHeldDelay = 3'd2;
`ifdef BTN_EDIT_AUTO_REPEAT_EN
  localparam logic [2:0] StHeldRep   = 3'd3;
`endif
  localparam logic [2:0] StDebRel    = 3'd4;

  // Synchronisers reset to the "released" raw level so no phantom press follows reset.
  localparam logic [NUM_BTN-1:0] RelVal = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] pulse_all;
  logic [NUM_BTN-1:0] level_all;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= RelVal;
      sync2_q <= RelVal;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : gen_btn
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;
    logic            level_q, level_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (pressed[g]) begin
            state_d = StDebPress;
            cnt_d   = '0;
          end
        end
        StDebPress: begin
          if (!pressed[g]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == DebLast) begin
            state_d = StHeldDelay;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHeldDelay: begin
          if (!pressed[g]) begin
            state_d = StDebRel;
            cnt_d   = '0;
          end
`ifdef BTN_EDIT_AUTO_REPEAT_EN
          else if (cnt_q == DelayLast) begin
            state_d = StHeldRep;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
`ifdef BTN_EDIT_AUTO_REPEAT_EN
        StHeldRep: begin
          if (!pressed[g]) begin
            state_d = StDebRel;
            cnt_d   = '0;
          end else if (cnt_q == RateLast) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        StDebRel: begin
          // A press seen while confirming release is a glitch: back to holding, the
          // repeat delay restarts and no pulse is emitted.
          if (pressed[g]) begin
            state_d = StHeldDelay;
            cnt_d   = '0;
          end else if (cnt_q == DebLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      level_d = (state_d == StHeldDelay) || (state_d == StDebRel);
`ifdef BTN_EDIT_AUTO_REPEAT_EN
      level_d = level_d || (state_d == StHeldRep);
`endif
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        level_q <= level_d;
      end
    end

    assign pulse_all[g] = pulse_q;
    assign level_all[g] = level_q;
  end

  assign bus.btn_edit_export = pulse_all;
  assign bus.btn_level       = level_all;

endmodule

// File: tb/tb_btn_edit_conditioner.sv
// Directed bench for btn_edit_conditioner (NUM_BTN=2, active-low keys, DEBOUNCE=4,
// REPEAT_DELAY=10, REPEAT_RATE=3). Expected pulses are queued with their cycle number
// when stimulus is driven; a negedge monitor compares every cycle's pulse vector.
module tb_btn_edit_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mask;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] mon_want;

  btn_edit_conditioner_if #(.NUM_BTN(2)) bus_if ();

  btn_edit_conditioner #(
    .NUM_BTN            (2),
    .ACTIVE_LOW         (1),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (3)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse scoreboard: every cycle outside reset, the pulse vector must equal the queued
  // expectation for that cycle, or zero when none is due.
  always @(negedge clk) begin
    if (!rst) begin
      mon_want = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_want = exp_q[0].mask;
        exp_q.pop_front();
      end
      checks++;
      assert (bus_if.btn_edit_export === mon_want) else begin
        errors++;
        $error("FAIL pulse@%0d: observed %b expected %b", cyc, bus_if.btn_edit_export,
               mon_want);
      end
    end
  end

  task automatic push(input int c, input logic [1:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge following edge t.
  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s@%0d: observed %b expected %b", tag, cyc, obs, want);
    end
  endtask

  int k;
  int r;

  initial begin
    bus_if.btn_raw = 2'b11;

    // Reset with keys released.
    goto(3);
    chk("rst_pulse", bus_if.btn_edit_export, 2'b00);
    chk("rst_level", bus_if.btn_level, 2'b00);
    rst = 1'b0;
    goto(cyc + 50);
    chk("idle_level", bus_if.btn_level, 2'b00);

    // Single clean press of button 0, held 8 cycles.
    k = cyc + 1;
    bus_if.btn_raw[0] = 1'b0;
    push(k + 6, 2'b01);
    goto(k + 5);
    chk("p0_lvl_pre", bus_if.btn_level, 2'b00);
    goto(k + 6);
    chk("p0_lvl_on", bus_if.btn_level, 2'b01);
    goto(k + 7);
    bus_if.btn_raw[0] = 1'b1;
    goto(k + 13);
    chk("p0_lvl_rel", bus_if.btn_level, 2'b01);
    goto(k + 14);
    chk("p0_lvl_off", bus_if.btn_level, 2'b00);

    // Bounce: toggles every cycle, never stable long enough.
    for (int j = 0; j < 4; j++) begin
      bus_if.btn_raw[0] = (j % 2 == 0) ? 1'b0 : 1'b1;
      goto(cyc + 1);
      chk("bounce_lvl", bus_if.btn_level, 2'b00);
    end
    goto(cyc + 10);
    chk("bounce_end", bus_if.btn_level, 2'b00);

    // Long hold on button 1: sampled pressed on edges k..k+39.
    k = cyc + 1;
    bus_if.btn_raw[1] = 1'b0;
    push(k + 6, 2'b10);
`ifdef BTN_EDIT_AUTO_REPEAT_EN
    for (int t = 16; t <= 41; t += 3) push(k + t, 2'b10);
`endif
    goto(k + 39);
    bus_if.btn_raw[1] = 1'b1;
    goto(k + 41);
    chk("hold_lvl", bus_if.btn_level, 2'b10);
    goto(k + 45);
    chk("hold_lvl_rel", bus_if.btn_level, 2'b10);
    goto(k + 46);
    chk("hold_lvl_off", bus_if.btn_level, 2'b00);

    // One-cycle release glitch on button 0 while held (sampled at edge k+20).
    k = cyc + 1;
    bus_if.btn_raw[0] = 1'b0;
    push(k + 6, 2'b01);
`ifdef BTN_EDIT_AUTO_REPEAT_EN
    push(k + 16, 2'b01);
    push(k + 19, 2'b01);
    push(k + 33, 2'b01);
    push(k + 36, 2'b01);
    push(k + 39, 2'b01);
`endif
    goto(k + 19);
    bus_if.btn_raw[0] = 1'b1;
    goto(k + 20);
    bus_if.btn_raw[0] = 1'b0;
    goto(k + 22);
    chk("glitch_lvl_a", bus_if.btn_level, 2'b01);
    goto(k + 23);
    chk("glitch_lvl_b", bus_if.btn_level, 2'b01);
    goto(k + 37);
    bus_if.btn_raw[0] = 1'b1;
    goto(k + 43);
    chk("glitch_lvl_rel", bus_if.btn_level, 2'b01);
    goto(k + 44);
    chk("glitch_lvl_off", bus_if.btn_level, 2'b00);

    // Both buttons together, then reset while held.
    goto(cyc + 3);
    k = cyc + 1;
    bus_if.btn_raw = 2'b00;
    push(k + 6, 2'b11);
    goto(k + 8);
    chk("both_lvl", bus_if.btn_level, 2'b11);
    #1 rst = 1'b1;
    #1;
    chk("midrst_pulse", bus_if.btn_edit_export, 2'b00);
    chk("midrst_level", bus_if.btn_level, 2'b00);
    goto(k + 10);
    rst = 1'b0;
    r = cyc;
    push(r + 7, 2'b11);
    goto(r + 6);
    chk("rerst_lvl_pre", bus_if.btn_level, 2'b00);
    goto(r + 7);
    chk("rerst_lvl_on", bus_if.btn_level, 2'b11);
    goto(r + 9);
    bus_if.btn_raw = 2'b11;
    goto(r + 20);
    chk("rerst_lvl_off", bus_if.btn_level, 2'b00);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending pulses expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
